uart_tx_fifo: RTL
=================

UART_TX_FIFO -- requirements
Module: uart_tx_fifo

Interface
REQ-001 The block SHALL have parameter DEPTH, default 16, giving FIFO entries; it is a power of two, 2..256.
REQ-002 The block SHALL have parameter AW, default 4, equal to log2(DEPTH).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-004 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port wr, input, 1 bit: write strobe; wdata is pushed this cycle.
REQ-006 The block SHALL have port wdata, input, 8 bits: byte to queue.
REQ-007 The block SHALL have port enable, input, 1 bit: permits launching new frames when 1.
REQ-008 The block SHALL have port clr_ovf, input, 1 bit: clears the sticky overflow flag.
REQ-009 The block SHALL have port tx_busy, input, 1 bit: busy from the downstream transmitter.
REQ-010 The block SHALL have port tx_en, output, 1 bit: one-cycle send pulse to the transmitter.
REQ-011 The block SHALL have port tx_data, output, 32 bits: {24'b0, byte}, valid while tx_en=1.
REQ-012 The block SHALL have port count, output, AW+1 bits: number of entries held.
REQ-013 The block SHALL have ports full and empty, outputs, 1 bit each: count==DEPTH and count==0.
REQ-014 The block SHALL have port ovf, output, 1 bit: sticky flag, set when a write is dropped.
REQ-015 The block SHALL have port idle, output, 1 bit: FSM in IDLE and empty=1.

Function
REQ-016 The FIFO SHALL be a circular buffer with AW-bit read and write pointers that wrap modulo DEPTH, plus an AW+1-bit count register.
REQ-017 A write with full=0 SHALL store wdata at the write pointer and advance the pointer at that edge.
REQ-018 A write with full=1 SHALL be dropped, even when a pop occurs in the same cycle, and SHALL set ovf at that edge.
REQ-019 A simultaneous accepted write and pop SHALL leave count unchanged and move both pointers.
REQ-020 ovf SHALL clear on clr_ovf=1; if clr_ovf and a dropped write fall in the same cycle, the set wins.
REQ-021 The launch FSM SHALL have four states: IDLE, START, ACK and DRAIN.
REQ-022 IDLE: moves to START when enable=1, empty=0 and tx_busy=0; the head byte is latched into tx_data and popped at that edge.
REQ-023 START: drives tx_en=1 for exactly this one cycle and always moves to ACK.
REQ-024 ACK: waits for tx_busy=1, then moves to DRAIN; tx_en=0.
REQ-025 DRAIN: waits for tx_busy=0, then moves to IDLE.
REQ-026 Launch latency SHALL be as follows: a byte written to an empty FIFO in cycle N (enable=1, tx_busy=0) is popped at the end of cycle N+1, and tx_en=1 in cycle N+2.
REQ-027 Minimum frame spacing SHALL be as follows: the next launch is evaluated in the first IDLE cycle after tx_busy falls, with no back-to-back tx_en pulses.
REQ-028 Deasserting enable SHALL only block new launches; a frame already in START, ACK or DRAIN SHALL complete.
REQ-029 tx_data SHALL hold its last launched value outside START; bits 31:8 SHALL always be 0.
REQ-030 count, full and empty SHALL be registered-state derived, reflecting the count after the most recent edge.

Reset
REQ-031 With reset=1 at an edge, the block SHALL set pointers=0, count=0, ovf=0, FSM=IDLE, tx_en=0 and tx_data=0; resulting outputs are empty=1, full=0 and idle=1.
REQ-032 Reset SHALL take priority over all inputs, including mid-frame, in START, ACK or DRAIN; queued data is discarded.
REQ-033 No output SHALL depend combinationally on reset.

Verification
REQ-034 The bench SHALL cover single byte: reset, then wr wdata=0x41 with tx_busy modelled 1 cycle after tx_en for 10 cycles -> one tx_en pulse two cycles after wr, tx_data=0x00000041, count 1 then 0, idle=1 at end.
REQ-035 The bench SHALL cover burst: write 0x01..0x05 on consecutive cycles -> tx_en pulses carry 0x01..0x05 in order, each pulse after tx_busy falls, never two pulses within one busy window.
REQ-036 The bench SHALL cover overflow: enable=0, write DEPTH+1 bytes -> count=16, full=1, ovf=1, last byte absent; clr_ovf -> ovf=0; enable=1 drains 16 bytes in order.
REQ-037 The bench SHALL cover wrap-around: push and pop 40 bytes with random gaps -> output order equals input order, pointers wrap past 15 without loss.
REQ-038 The bench SHALL cover simultaneous events: full FIFO with pop and wr in one cycle -> write dropped, ovf=1, count=15; a cycle with wr, clr_ovf and full=1 -> ovf stays 1.
REQ-039 The bench SHALL cover reset mid-operation: reset asserted in ACK with 3 bytes queued -> next cycle tx_en=0, count=0, empty=1, FSM=IDLE, no further tx_en pulses.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Byte FIFO feeding a UART transmitter: queues bytes and launches one frame at a
// time with a single-cycle tx_en pulse, pacing launches on the transmitter's busy.
module uart_tx_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          wr,
    input  logic [7:0]    wdata,
    input  logic          enable,
    input  logic          clr_ovf,
    input  logic          tx_busy,
    output logic          tx_en,
    output logic [31:0]   tx_data,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty,
    output logic          ovf,
    output logic          idle
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_ACK   = 2'd2,
        S_DRAIN = 2'd3
    } state_e;

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wptr_q;
    logic [AW-1:0] rptr_q;
    logic [AW:0]   count_q;
    logic [AW:0]   count_d;
    logic          full_q;
    logic          empty_q;
    logic          ovf_q;
    logic          tx_en_q;
    logic [7:0]    tx_byte_q;
    state_e        state_q;
    logic          push;
    logic          pop;

    // A write into a full FIFO is dropped even if a pop frees a slot this cycle.
    assign push = wr && !full_q;
    assign pop  = (state_q == S_IDLE) && enable && !empty_q && !tx_busy;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wptr_q] <= wdata;
        end
    end

    // Pointers, occupancy and flags; full/empty are registered from the next count.
    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + AW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + AW'(1);
            end
            count_q <= count_d;
            full_q  <= (count_d == FULL_CNT);
            empty_q <= (count_d == '0);
        end
    end

    // Sticky overflow: a dropped write beats a simultaneous clear.
    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (wr && full_q) begin
            ovf_q <= 1'b1;
        end else if (clr_ovf) begin
            ovf_q <= 1'b0;
        end
    end

    // Launch FSM: IDLE pops the head byte, START pulses tx_en, ACK/DRAIN track busy.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            tx_en_q   <= 1'b0;
            tx_byte_q <= 8'h00;
        end else begin
            tx_en_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        state_q   <= S_START;
                        tx_en_q   <= 1'b1;
                        tx_byte_q <= mem_q[rptr_q];
                    end
                end
                S_START: begin
                    state_q <= S_ACK;
                end
                S_ACK: begin
                    if (tx_busy) begin
                        state_q <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (!tx_busy) begin
                        state_q <= S_IDLE;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign tx_en   = tx_en_q;
    assign tx_data = {24'h000000, tx_byte_q};
    assign count   = count_q;
    assign full    = full_q;
    assign empty   = empty_q;
    assign ovf     = ovf_q;
    assign idle    = (state_q == S_IDLE) && empty_q;

endmodule
